// File: rtl/dcache_2way_if.sv
// CPU-side and memory-side bus of the 2-way data cache.
// The cache connects through the slave modport; whoever drives the CPU
// request and plays the memory connects through the master modport.
interface dcache_2way_if #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int OFFSET_W = 2
);
  localparam int BLOCK_W = DATA_W << OFFSET_W;

  logic                         READ;
  logic                         WRITE;
  logic [ADDR_W-1:0]            ADDRESS;
  logic [DATA_W-1:0]            WRITEDATA;
  logic [DATA_W-1:0]            READDATA;
  logic                         dBUSYWAIT;
  logic                         mem_read;
  logic                         mem_write;
  logic [ADDR_W-OFFSET_W-1:0]   mem_address;
  logic [BLOCK_W-1:0]           mem_writedata;
  logic [BLOCK_W-1:0]           mem_readdata;
  logic                         mem_busywait;

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, mem_readdata, mem_busywait,
    input  READDATA, dBUSYWAIT, mem_read, mem_write, mem_address, mem_writedata
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, mem_readdata, mem_busywait,
    output READDATA, dBUSYWAIT, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_2way.sv
// 2-way set-associative, write-back, write-allocate data cache.
// Hits complete in IDLE with no stall; misses walk WRITEBACK (dirty victim
// only) -> ALLOCATE -> UPDATE and then retire the access as a hit in IDLE.
module dcache_2way #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int INDEX_W  = 2,
  parameter int OFFSET_W = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  dcache_2way_if.slave  bus
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;
  typedef logic [WORDS-1:0][DATA_W-1:0] block_t;

  state_t r_state, w_next;

  // Per-way storage; LRU bit names the way to evict next.
  block_t                    r_data [2][SETS];
  logic [TAG_W-1:0]          r_tag  [2][SETS];
  logic [1:0][SETS-1:0]      r_valid;
  logic [1:0][SETS-1:0]      r_dirty;
  logic [SETS-1:0]           r_lru;
  logic [DATA_W-1:0]         r_rdata;

  // Miss context captured on leaving IDLE so the memory-side address and
  // data cannot move while a strobe is up, whatever the CPU does meanwhile.
  logic [TAG_W-1:0]          r_mtag;
  logic [INDEX_W-1:0]        r_midx;
  logic                      r_victim;

  logic [TAG_W-1:0]          w_tag;
  logic [INDEX_W-1:0]        w_idx;
  logic [OFFSET_W-1:0]       w_off;
  logic                      w_req, w_wr, w_rd;
  logic [1:0]                w_way_hit;
  logic                      w_hit, w_hit_way;
  logic [DATA_W-1:0]         w_hit_word;
  logic                      w_victim, w_victim_dirty;
  logic                      w_idle_hit, w_idle_miss;
  logic                      w_mem_read, w_mem_write, w_busy;
  logic [ADDR_W-OFFSET_W-1:0] w_mem_address;
  block_t                    w_mem_writedata;

  assign w_tag = bus.ADDRESS[ADDR_W-1 -: TAG_W];
  assign w_idx = bus.ADDRESS[OFFSET_W +: INDEX_W];
  assign w_off = bus.ADDRESS[OFFSET_W-1:0];

  // READ and WRITE together behave as a write.
  assign w_req = bus.READ | bus.WRITE;
  assign w_wr  = bus.WRITE;
  assign w_rd  = bus.READ & ~bus.WRITE;

  assign w_way_hit[0] = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_way_hit[1] = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit        = |w_way_hit;
  assign w_hit_way    = ~w_way_hit[0];
  assign w_hit_word   = r_data[w_hit_way][w_idx][w_off];

  // First invalid way wins (way0 before way1), else the LRU way.
  assign w_victim = ~r_valid[0][w_idx] ? 1'b0 :
                    ~r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
  assign w_victim_dirty = r_valid[w_victim][w_idx] & r_dirty[w_victim][w_idx];

  assign w_idle_hit  = (r_state == IDLE) & w_req & w_hit;
  assign w_idle_miss = (r_state == IDLE) & w_req & ~w_hit;

  // Loads are combinational on a hit; otherwise the last hit word is held.
  assign bus.READDATA = (w_idle_hit & w_rd) ? w_hit_word : r_rdata;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and memory/CPU handshake outputs.
  always_comb begin
    w_next          = r_state;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_busy          = 1'b1;
    w_mem_address   = {r_mtag, r_midx};
    w_mem_writedata = r_data[r_victim][r_midx];
    case (r_state)
      IDLE: begin
        w_busy = w_req & ~w_hit;
        if (w_req && !w_hit) w_next = w_victim_dirty ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        w_mem_write   = 1'b1;
        w_mem_address = {r_tag[r_victim][r_midx], r_midx};
        if (!bus.mem_busywait) w_next = ALLOCATE;
      end
      ALLOCATE: begin
        w_mem_read = 1'b1;
        if (!bus.mem_busywait) w_next = UPDATE;
      end
      UPDATE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign bus.mem_read      = w_mem_read;
  assign bus.mem_write     = w_mem_write;
  assign bus.mem_address   = w_mem_address;
  assign bus.mem_writedata = w_mem_writedata;
  assign bus.dBUSYWAIT     = w_busy;

  // Cache arrays: miss capture, block fill, and hit-side write/LRU update.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_valid  <= '0;
      r_dirty  <= '0;
      r_lru    <= '0;
      r_rdata  <= '0;
      r_mtag   <= '0;
      r_midx   <= '0;
      r_victim <= 1'b0;
    end else begin
      if (w_idle_miss) begin
        r_mtag   <= w_tag;
        r_midx   <= w_idx;
        r_victim <= w_victim;
      end
      if (r_state == ALLOCATE && !bus.mem_busywait) begin
        r_data[r_victim][r_midx]  <= bus.mem_readdata;
        r_tag[r_victim][r_midx]   <= r_mtag;
        r_valid[r_victim][r_midx] <= 1'b1;
        r_dirty[r_victim][r_midx] <= 1'b0;
      end
      if (w_idle_hit) begin
        r_lru[w_idx] <= ~w_hit_way;
        if (w_wr) begin
          r_data[w_hit_way][w_idx][w_off] <= bus.WRITEDATA;
          r_dirty[w_hit_way][w_idx]       <= 1'b1;
        end else begin
          r_rdata <= w_hit_word;
        end
      end
    end
  end
endmodule

// File: tb/tb_dcache_2way.sv
// Bench for dcache_2way: directed scenarios then random traffic, checked
// against an abstract cache model and a latency-randomised memory.
module tb_dcache_2way;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  dcache_2way_if #(.ADDR_W(8), .DATA_W(8), .OFFSET_W(2)) bus ();
  dcache_2way #(.ADDR_W(8), .DATA_W(8), .INDEX_W(2), .OFFSET_W(2)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {logic wr; logic [5:0] addr; logic [31:0] data;} xfer_t;
  xfer_t log_q[$];
  xfer_t exp_q[$];

  // Memory: busy until mem_lat extra cycles have elapsed on a strobe.
  logic [31:0] tmem [64];
  bit  mem_init = 1'b0;
  int  mem_cnt = 0;
  int  mem_lat = 0;
  int  fixed_lat = -1;

  assign bus.mem_readdata = tmem[bus.mem_address];
  assign bus.mem_busywait = (bus.mem_read | bus.mem_write) && (mem_cnt != mem_lat);

  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) tmem[i] <= (i == 0) ? 32'h44332211 : $urandom;
      mem_init <= 1'b1;
    end
    if (bus.mem_read | bus.mem_write) begin
      if (mem_cnt == mem_lat) begin
        if (bus.mem_write) tmem[bus.mem_address] <= bus.mem_writedata;
        log_q.push_back(xfer_t'{bus.mem_write, bus.mem_address,
                                bus.mem_write ? bus.mem_writedata : bus.mem_readdata});
        mem_cnt <= 0;
        mem_lat <= (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
      mem_lat <= (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    end
  end

  // Reference model: sets x ways of {valid, dirty, tag, block}, LRU per set.
  bit          m_v [4][2];
  bit          m_d [4][2];
  int          m_t [4][2];
  logic [31:0] m_b [4][2];
  bit          m_lru [4];
  logic [31:0] m_mem [64];

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int s = 0; s < 4; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_v[s][w] = 1'b0;
        m_d[s][w] = 1'b0;
      end
    end
  endtask

  // Bring the block in (with any writeback) and report which way holds it.
  task automatic m_miss(input logic [7:0] a, output int way, output bit hit);
    int tag, idx, vb;
    tag = int'(a) / 16;
    idx = (int'(a) / 4) % 4;
    way = -1;
    for (int w = 0; w < 2; w++) if (m_v[idx][w] && m_t[idx][w] == tag) way = w;
    hit = (way >= 0);
    if (!hit) begin
      way = !m_v[idx][0] ? 0 : !m_v[idx][1] ? 1 : int'(m_lru[idx]);
      if (m_v[idx][way] && m_d[idx][way]) begin
        vb = m_t[idx][way] * 4 + idx;
        exp_q.push_back(xfer_t'{1'b1, 6'(vb), m_b[idx][way]});
        m_mem[vb] = m_b[idx][way];
      end
      exp_q.push_back(xfer_t'{1'b0, 6'(tag * 4 + idx), m_mem[tag * 4 + idx]});
      m_b[idx][way] = m_mem[tag * 4 + idx];
      m_v[idx][way] = 1'b1;
      m_d[idx][way] = 1'b0;
      m_t[idx][way] = tag;
    end
  endtask

  task automatic m_finish(input logic [7:0] a, input bit wr, input logic [7:0] wd,
                          input int way, output logic [7:0] rd);
    int idx, off;
    idx = (int'(a) / 4) % 4;
    off = int'(a) % 4;
    rd = m_b[idx][way][off*8 +: 8];
    if (wr) begin
      m_b[idx][way][off*8 +: 8] = wd;
      m_d[idx][way] = 1'b1;
    end
    m_lru[idx] = (way == 0);
  endtask

  task automatic chk_traffic(input string nm);
    chk({nm, ":nxfer"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk({nm, ":xfer"}, 64'(log_q[i]), 64'(exp_q[i]));
  endtask

  task automatic do_access(input bit rd, input bit wr, input logic [7:0] a,
                           input logic [7:0] wd, input string nm);
    int way, n;
    bit hit;
    logic [7:0] exp;
    log_q.delete();
    exp_q.delete();
    m_miss(a, way, hit);
    m_finish(a, wr, wd, way, exp);
    @(negedge CLK);
    bus.READ = rd; bus.WRITE = wr; bus.ADDRESS = a; bus.WRITEDATA = wd;
    #1;
    chk({nm, ":stall"}, 64'(bus.dBUSYWAIT), 64'(!hit));
    n = 0;
    while (bus.dBUSYWAIT && n < 100) begin
      @(negedge CLK); #1; n++;
    end
    chk({nm, ":done"}, 64'(n < 100), 64'd1);
    if (rd && !wr) chk({nm, ":rdata"}, 64'(bus.READDATA), 64'(exp));
    chk({nm, ":strobe"}, 64'({bus.mem_read, bus.mem_write}), 64'd0);
    @(posedge CLK); #1;
    bus.READ = 1'b0; bus.WRITE = 1'b0;
    chk_traffic(nm);
  endtask

  // Request a miss, withdraw it after one edge, let the cache finish alone.
  task automatic drop_miss(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                           input string nm);
    int way;
    bit hit;
    log_q.delete();
    exp_q.delete();
    m_miss(a, way, hit);
    @(negedge CLK);
    bus.READ = ~wr; bus.WRITE = wr; bus.ADDRESS = a; bus.WRITEDATA = wd;
    @(posedge CLK); #1;
    bus.READ = 1'b0; bus.WRITE = 1'b0;
    repeat (40) @(negedge CLK);
    #1;
    chk({nm, ":idle"}, 64'({bus.mem_read, bus.mem_write, bus.dBUSYWAIT}), 64'd0);
    chk_traffic(nm);
  endtask

  initial begin
    int n;
    bit op_rd, op_wr;
    bus.READ = 1'b0; bus.WRITE = 1'b0; bus.ADDRESS = '0; bus.WRITEDATA = '0;

    // Reset
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    chk("rst:strobes", 64'({bus.mem_read, bus.mem_write}), 64'd0);
    chk("rst:busy", 64'(bus.dBUSYWAIT), 64'd0);
    chk("rst:rdata", 64'(bus.READDATA), 64'd0);
    RESET = 1'b1;
    for (int i = 0; i < 64; i++) m_mem[i] = tmem[i];
    m_reset();

    // Fill, hits, write hit, read+write as write
    do_access(1, 0, 8'h00, 8'h00, "rd00");
    do_access(1, 0, 8'h03, 8'h00, "rd03");
    chk("rd03:val", 64'(bus.READDATA), 64'h44);
    do_access(0, 1, 8'h01, 8'hAA, "wr01");
    do_access(1, 0, 8'h01, 8'h00, "rd01");
    do_access(1, 1, 8'h02, 8'h5C, "rw02");
    do_access(1, 0, 8'h02, 8'h00, "rd02");

    // Set-0 conflicts: LRU replacement and dirty writeback
    do_access(1, 0, 8'h40, 8'h00, "rd40");
    do_access(1, 0, 8'h00, 8'h00, "re00");
    do_access(1, 0, 8'h80, 8'h00, "rd80");
    do_access(1, 0, 8'hC0, 8'h00, "rdC0");
    chk("rdC0:wb_byte1", 64'(log_q[0].data[15:8]), 64'hAA);

    // Withdrawn miss: fill happens, no word modified
    drop_miss(1, 8'h24, 8'hEE, "drop24");
    do_access(1, 0, 8'h24, 8'h00, "rd24");

    // Random traffic
    for (int k = 0; k < 80; k++) begin
      n = $urandom_range(0, 2);
      op_rd = (n != 1);
      op_wr = (n != 0);
      do_access(op_rd, op_wr, 8'($urandom), 8'($urandom), "rand");
    end

    // Reset in the middle of ALLOCATE
    do_access(1, 0, 8'h00, 8'h00, "pre_rst");
    fixed_lat = 5;
    repeat (2) @(negedge CLK);
    log_q.delete();
    bus.READ = 1'b1; bus.ADDRESS = 8'h14;
    n = 0;
    #1;
    while (!bus.mem_read && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    chk("rst_alloc:seen", 64'(bus.mem_read), 64'd1);
    RESET = 1'b0;
    @(posedge CLK); #1;
    chk("rst_alloc:strobes", 64'({bus.mem_read, bus.mem_write}), 64'd0);
    bus.READ = 1'b0;
    @(negedge CLK); #1;
    chk("rst_alloc:rdata", 64'(bus.READDATA), 64'd0);
    RESET = 1'b1;
    m_reset();
    fixed_lat = -1;
    repeat (2) @(negedge CLK);
    do_access(1, 0, 8'h00, 8'h00, "post_rst00");
    do_access(1, 0, 8'h14, 8'h00, "post_rst14");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end
endmodule

// File: doc/dcache_2way.md
DCACHE_2WAY -- requirements
Module: dcache_2way

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning CPU byte-address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning CPU data width.
REQ-003 SHALL have parameter INDEX_W, default 2, meaning log2 of the set count.
REQ-004 SHALL have parameter OFFSET_W, default 2, meaning log2 of words per block; BLOCK_W = DATA_W*2^OFFSET_W; TAG_W = ADDR_W-INDEX_W-OFFSET_W.
REQ-005 SHALL have port CLK  in  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port RESET  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports READ and WRITE  in  1 each  CPU access strobes.
REQ-008 SHALL have port ADDRESS  in  ADDR_W  CPU address, split as {tag, index, offset}.
REQ-009 SHALL have ports WRITEDATA  in  DATA_W  store data, and READDATA  out  DATA_W  load data.
REQ-010 SHALL have port dBUSYWAIT  out  1  CPU stall request.
REQ-011 SHALL have ports mem_read and mem_write  out  1 each  memory strobes.
REQ-012 SHALL have port mem_address  out  ADDR_W-OFFSET_W  block address.
REQ-013 SHALL have ports mem_writedata  out  BLOCK_W  and mem_readdata  in  BLOCK_W  block data.
REQ-014 SHALL have port mem_busywait  in  1  memory busy; memory drives it high combinationally in any cycle a strobe is high and the transfer is incomplete.

Function
REQ-015 SHALL be 2-way set-associative, write-back, write-allocate, with per-way valid, dirty and tag, and one LRU bit per set.
REQ-016 SHALL treat READ and WRITE both high as a write.
REQ-017 SHALL declare a hit when a valid way in the indexed set has a matching tag; hit detection combinational.
REQ-018 SHALL, on a read hit in IDLE, drive READDATA with the offset-selected word combinationally and hold dBUSYWAIT low.
REQ-019 SHALL, on a write hit in IDLE, write WRITEDATA into the selected word and set dirty at the next rising edge, with dBUSYWAIT low.
REQ-020 SHALL update LRU at the edge that completes a hit so that it points to the other way.
REQ-021 SHALL select the victim as the first invalid way (way0 first), otherwise the LRU way.
REQ-022 SHALL drive dBUSYWAIT = (READ|WRITE) & ~hit in IDLE, and 1 in every other state.
REQ-023 SHALL implement states IDLE, WRITEBACK, ALLOCATE and UPDATE.
REQ-024 SHALL transition from IDLE to WRITEBACK on a request that misses with a dirty victim, to ALLOCATE on a request that misses with a clean or invalid victim, and otherwise stay in IDLE.
REQ-025 SHALL, in WRITEBACK, assert mem_write=1 with mem_address={victim tag, index} and mem_writedata=victim block, and go to ALLOCATE at the first edge with mem_busywait=0.
REQ-026 SHALL, in ALLOCATE, assert mem_read=1 with mem_address={tag, index}, and go to UPDATE at the first edge with mem_busywait=0, latching mem_readdata into the victim way (valid=1, dirty=0, tag written).
REQ-027 SHALL spend exactly one cycle in UPDATE with no strobes, then return to IDLE, where the pending access completes as a hit.
REQ-028 SHALL keep mem_address and mem_writedata stable while a strobe is high, and deassert both strobes in IDLE and UPDATE.
REQ-029 SHALL finish the memory sequence and return to IDLE if READ and WRITE drop mid-miss, without modifying any word.
REQ-030 SHALL require the CPU to hold ADDRESS and WRITEDATA constant while dBUSYWAIT=1.

Reset
REQ-031 SHALL, at a rising edge with RESET=0, force state to IDLE, clear all valid, dirty and LRU bits, and drive mem_read=0 and mem_write=0, aborting any memory transfer in progress.
REQ-032 SHALL drive READDATA=0 after reset until the first hit; reset SHALL take priority over all other activity in that cycle.

Verification (defaults: tag 4b, 4 sets, 4 words per block)
REQ-033 SHALL cover: reset, then read 0x00 -> one ALLOCATE at mem_address 0x00; memory returns 0x44332211 -> READDATA 0x11; a following read of 0x03 -> READDATA 0x44 with dBUSYWAIT=0 and no strobe.
REQ-034 SHALL cover: write 0x01 with 0xAA on a hit -> no strobe, dirty set; read 0x01 -> 0xAA.
REQ-035 SHALL cover: reads 0x00 then 0x40 (set 0) -> allocations at 0x00 and 0x10; a re-read of 0x00 -> hit with no traffic.
REQ-036 SHALL cover: with 0x00 dirty and 0x40 resident, after an access to 0x00, read 0x80 -> ALLOCATE 0x20 only, replacing 0x40; then read 0xC0 -> WRITEBACK at 0x00 with byte 1 = 0xAA, then ALLOCATE 0x30.
REQ-037 SHALL cover: RESET low during ALLOCATE -> mem_read=0 at the next edge; a subsequent read of 0x00 misses.
REQ-038 SHALL cover: READ=WRITE=1 at 0x02 with 0x5C on a hit -> word written and dirty set; read 0x02 -> 0x5C.
